cache_controller: RTL and testbench
===================================

Name: cache_controller

Overview:
- Read-only cache controller for the rvscc load/fetch path. Sits directly upstream of cache_memory.
- Accepts CPU read requests and splits the address into tag/set/offset. Drives cache_memory lookup.
- On a miss: selects a victim way, fetches the block from main memory over a valid/ready handshake, writes it into cache_memory, then returns the data to the CPU.

Parameters:
ADDR_SIZE, 32, byte address width
NUM_SETS, 16, sets in cache_memory (power of 2)
NUM_WAYS, 4, ways per set (power of 2, >=2)
BLOCK_SIZE, 32, block width in bits; offset field = $clog2(BLOCK_SIZE/4) bits

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
cpu_req_valid  in  1  CPU read request
cpu_req_ready  out  1  controller can accept a request
cpu_addr  in  ADDR_SIZE  request address
cpu_resp_valid  out  1  one-cycle response strobe
cpu_resp_data  out  BLOCK_SIZE  response data
cache_set  out  $clog2(NUM_SETS)  set index to cache_memory
cache_tag  out  TagSize  tag to cache_memory
cache_write_enable  out  1  fill strobe
cache_write_way  out  $clog2(NUM_WAYS)  fill way
cache_write_data  out  BLOCK_SIZE  fill data
cache_read_data  in  BLOCK_SIZE  cache_memory read data (combinational)
cache_hit  in  1  cache_memory hit
cache_populate_way  in  $clog2(NUM_WAYS)  next free way
cache_populated  in  1  set full (all ways valid)
mem_req_valid  out  1  memory read request
mem_req_ready  in  1  memory accepts request
mem_addr  out  ADDR_SIZE  block-aligned address (offset bits zero)
mem_resp_valid  in  1  memory data valid
mem_resp_data  in  BLOCK_SIZE  memory data

Behaviour:
- Reset (rst=0, async) values:
  - FSM=IDLE; all round-robin pointers = 0.
  - cpu_req_ready=0 while rst is asserted, 1 after reset in IDLE.
  - cpu_resp_valid=0, cpu_resp_data=0.
  - mem_req_valid=0, mem_addr=0.
  - cache_write_enable=0, cache_write_way=0, cache_write_data=0.
  - cache_set/cache_tag are driven from the address register, which resets to 0.
- Reset mid-operation: aborts immediately to IDLE and drops mem_req_valid. A later mem_resp_valid received in IDLE is ignored.
- Address split (from latched addr_q):
  - tag = addr[ADDR_SIZE-1 : SetSize+OffSize]
  - set = addr[SetSize+OffSize-1 : OffSize]
- IDLE: cpu_req_ready=1. On cpu_req_valid: latch cpu_addr into addr_q, go LOOKUP.
- LOOKUP (one cycle):
  - Hit: latch cache_read_data into cpu_resp_data, go RESP.
  - Miss: victim = cache_populated ? rr[set] : cache_populate_way. Latch victim and the was_rr flag, go MEM_REQ.
- MEM_REQ: mem_req_valid=1, mem_addr=addr_q with offset bits cleared. Both are held stable until mem_req_ready=1 in the same cycle, then go MEM_WAIT.
- MEM_WAIT: on mem_resp_valid, latch mem_resp_data, go FILL. A mem_resp_valid arriving while still in MEM_REQ is not legal; memory responds only after accepting the request.
- FILL (one cycle):
  - cache_write_enable=1, cache_write_way=victim, cache_write_data=fill data.
  - cpu_resp_data <= fill data.
  - If was_rr: rr[set] <= rr[set]+1, wrapping modulo NUM_WAYS (NUM_WAYS-1 -> 0).
  - Go RESP.
- RESP: cpu_resp_valid=1 for exactly one cycle, then IDLE. The CPU response has no backpressure.
- Latency:
  - Hit: request accepted at edge 0, cpu_resp_valid high in cycle 2.
  - Miss: 4 cycles + memory handshake time.
- cpu_req_ready=0 in every state except IDLE.
- Round-robin pointers advance only on fills into a full set. Fills into a set with a free way never touch rr.
- cache_memory's own synchronous reset is driven at top level, not by this block.

Optional Feature:
- Macro: CACHE_STATS_EN
- Defined:
  - Adds outputs stat_hits[31:0] and stat_misses[31:0].
  - stat_hits increments on a LOOKUP hit; stat_misses increments on a LOOKUP miss.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: no stats ports, no stats logic.

Decomposition:
- Package cache_pkg holds:
  - enum cache_state_e {IDLE, LOOKUP, MEM_REQ, MEM_WAIT, FILL, RESP}.
  - Functions computing SetSize, OffSize and TagSize from the parameters.
- One sub-module: cache_rr_table, holding the per-set round-robin pointers.
  - Inputs: read set, increment strobe.
  - Output: pointer.
  - Async active-low reset.

Test Plan:
- Cold miss: addr 0x0000_1040, memory returns 0xDEADBEEF → mem_addr=0x0000_1040; fill way 0; cpu_resp_data=0xDEADBEEF; then repeat same addr → hit, resp in cycle 2, no mem_req_valid.
- Set fill order: 4 misses to set 2 with distinct tags → write_way 0,1,2,3 in order; rr[2] stays 0.
- Replacement: 5th and 6th distinct-tag misses to set 2 → victims rr=0 then 1; rr[2]=2 afterwards; rr of other sets unchanged.
- Handshake stall: hold mem_req_ready=0 for 7 cycles → mem_req_valid and mem_addr stable, cpu_req_ready=0 throughout; response arrives after ready.
- Reset mid-miss: assert rst in MEM_WAIT → outputs at reset values immediately; stray mem_resp_valid afterwards → no fill, no cpu_resp_valid.
- CACHE_STATS_EN: 3 hits, 2 misses → stat_hits=3, stat_misses=2.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and field-width helpers for the read-only cache controller.
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MEM_REQ,
        MEM_WAIT,
        FILL,
        RESP
    } cache_state_e;

    function automatic int unsigned set_size(input int unsigned num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int unsigned off_size(input int unsigned block_size);
        return $clog2(block_size / 4);
    endfunction

    function automatic int unsigned way_size(input int unsigned num_ways);
        return $clog2(num_ways);
    endfunction

    function automatic int unsigned tag_size(input int unsigned addr_size,
                                             input int unsigned num_sets,
                                             input int unsigned block_size);
        return addr_size - set_size(num_sets) - off_size(block_size);
    endfunction

endpackage

// File: rtl/cache_rr_table.sv
// Per-set round-robin victim pointers, advanced only on fills into full sets.
module cache_rr_table
    import cache_pkg::*;
#(
    parameter int unsigned NUM_SETS = 16,
    parameter int unsigned NUM_WAYS = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [set_size(NUM_SETS)-1:0]   rd_set,
    input  logic                            inc,
    output logic [way_size(NUM_WAYS)-1:0]   rr_ptr_c
);

    localparam int unsigned WayW = way_size(NUM_WAYS);

    logic [WayW-1:0] rr_q [NUM_SETS];
    logic [WayW-1:0] rr_d [NUM_SETS];

    // NUM_WAYS is a power of two, so natural overflow gives the modulo wrap
    always_comb begin
        rr_d = rr_q;
        if (inc) begin
            rr_d[rd_set] = WayW'(rr_q[rd_set] + WayW'(1));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                rr_q[s] <= '0;
            end
        end else begin
            rr_q <= rr_d;
        end
    end

    assign rr_ptr_c = rr_q[rd_set];

endmodule

// File: rtl/cache_controller.sv
// Read-only cache controller: lookup, victim select, memory fill, CPU response.
// Optional hit/miss counters are built when CACHE_STATS_EN is defined.
module cache_controller
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_SIZE  = 32,
    parameter int unsigned NUM_SETS   = 16,
    parameter int unsigned NUM_WAYS   = 4,
    parameter int unsigned BLOCK_SIZE = 32
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic                                               cpu_req_valid,
    output logic                                               cpu_req_ready,
    input  logic [ADDR_SIZE-1:0]                               cpu_addr,
    output logic                                               cpu_resp_valid,
    output logic [BLOCK_SIZE-1:0]                              cpu_resp_data,
    output logic [set_size(NUM_SETS)-1:0]                      cache_set,
    output logic [tag_size(ADDR_SIZE,NUM_SETS,BLOCK_SIZE)-1:0] cache_tag,
    output logic                                               cache_write_enable,
    output logic [way_size(NUM_WAYS)-1:0]                      cache_write_way,
    output logic [BLOCK_SIZE-1:0]                              cache_write_data,
    input  logic [BLOCK_SIZE-1:0]                              cache_read_data,
    input  logic                                               cache_hit,
    input  logic [way_size(NUM_WAYS)-1:0]                      cache_populate_way,
    input  logic                                               cache_populated,
    output logic                                               mem_req_valid,
    input  logic                                               mem_req_ready,
    output logic [ADDR_SIZE-1:0]                               mem_addr,
    input  logic                                               mem_resp_valid,
    input  logic [BLOCK_SIZE-1:0]                              mem_resp_data
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]                                        stat_hits,
    output logic [31:0]                                        stat_misses
`endif
);

    localparam int unsigned SetSize = set_size(NUM_SETS);
    localparam int unsigned OffSize = off_size(BLOCK_SIZE);
    localparam int unsigned TagSize = tag_size(ADDR_SIZE, NUM_SETS, BLOCK_SIZE);
    localparam int unsigned WayW    = way_size(NUM_WAYS);
    localparam logic [ADDR_SIZE-1:0] OffMask = ADDR_SIZE'((64'd1 << OffSize) - 64'd1);

    cache_state_e           state_q, state_d;
    logic [ADDR_SIZE-1:0]   addr_q, addr_d;
    logic [WayW-1:0]        victim_q, victim_d;
    logic                   was_rr_q, was_rr_d;
    logic                   cpu_req_ready_q, cpu_req_ready_d;
    logic                   cpu_resp_valid_q, cpu_resp_valid_d;
    logic [BLOCK_SIZE-1:0]  cpu_resp_data_q, cpu_resp_data_d;
    logic                   mem_req_valid_q, mem_req_valid_d;
    logic [ADDR_SIZE-1:0]   mem_addr_q, mem_addr_d;
    logic                   wr_en_q, wr_en_d;
    logic [WayW-1:0]        wr_way_q, wr_way_d;
    logic [BLOCK_SIZE-1:0]  wr_data_q, wr_data_d;
    logic [WayW-1:0]        rr_ptr_c;
    logic                   rr_inc;

    assign cache_tag = addr_q[ADDR_SIZE-1 -: TagSize];
    assign cache_set = addr_q[OffSize +: SetSize];

    cache_rr_table #(
        .NUM_SETS (NUM_SETS),
        .NUM_WAYS (NUM_WAYS)
    ) u_rr_table (
        .clk      (clk),
        .rst      (rst),
        .rd_set   (cache_set),
        .inc      (rr_inc),
        .rr_ptr_c (rr_ptr_c)
    );

    // Next-state and registered-output computation
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        victim_d        = victim_q;
        was_rr_d        = was_rr_q;
        cpu_resp_data_d = cpu_resp_data_q;
        mem_addr_d      = mem_addr_q;
        wr_way_d        = wr_way_q;
        wr_data_d       = wr_data_q;
        rr_inc          = 1'b0;

        case (state_q)
            IDLE: begin
                if (cpu_req_valid && cpu_req_ready_q) begin
                    addr_d  = cpu_addr;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (cache_hit) begin
                    cpu_resp_data_d = cache_read_data;
                    state_d         = RESP;
                end else begin
                    victim_d   = cache_populated ? rr_ptr_c : cache_populate_way;
                    was_rr_d   = cache_populated;
                    mem_addr_d = addr_q & ~OffMask;
                    state_d    = MEM_REQ;
                end
            end
            MEM_REQ: begin
                if (mem_req_ready) begin
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (mem_resp_valid) begin
                    wr_data_d = mem_resp_data;
                    wr_way_d  = victim_q;
                    state_d   = FILL;
                end
            end
            FILL: begin
                cpu_resp_data_d = wr_data_q;
                rr_inc          = was_rr_q;
                state_d         = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cpu_req_ready_d  = (state_d == IDLE);
        cpu_resp_valid_d = (state_d == RESP);
        mem_req_valid_d  = (state_d == MEM_REQ);
        wr_en_d          = (state_d == FILL);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= IDLE;
            addr_q           <= '0;
            victim_q         <= '0;
            was_rr_q         <= 1'b0;
            cpu_req_ready_q  <= 1'b0;
            cpu_resp_valid_q <= 1'b0;
            cpu_resp_data_q  <= '0;
            mem_req_valid_q  <= 1'b0;
            mem_addr_q       <= '0;
            wr_en_q          <= 1'b0;
            wr_way_q         <= '0;
            wr_data_q        <= '0;
        end else begin
            state_q          <= state_d;
            addr_q           <= addr_d;
            victim_q         <= victim_d;
            was_rr_q         <= was_rr_d;
            cpu_req_ready_q  <= cpu_req_ready_d;
            cpu_resp_valid_q <= cpu_resp_valid_d;
            cpu_resp_data_q  <= cpu_resp_data_d;
            mem_req_valid_q  <= mem_req_valid_d;
            mem_addr_q       <= mem_addr_d;
            wr_en_q          <= wr_en_d;
            wr_way_q         <= wr_way_d;
            wr_data_q        <= wr_data_d;
        end
    end

    assign cpu_req_ready      = cpu_req_ready_q;
    assign cpu_resp_valid     = cpu_resp_valid_q;
    assign cpu_resp_data      = cpu_resp_data_q;
    assign mem_req_valid      = mem_req_valid_q;
    assign mem_addr           = mem_addr_q;
    assign cache_write_enable = wr_en_q;
    assign cache_write_way    = wr_way_q;
    assign cache_write_data   = wr_data_q;

`ifdef CACHE_STATS_EN
    logic [31:0] stat_hits_q, stat_hits_d;
    logic [31:0] stat_misses_q, stat_misses_d;

    // Saturating lookup counters
    always_comb begin
        stat_hits_d   = stat_hits_q;
        stat_misses_d = stat_misses_q;
        if (state_q == LOOKUP) begin
            if (cache_hit && (stat_hits_q != 32'hFFFF_FFFF)) begin
                stat_hits_d = stat_hits_q + 32'd1;
            end
            if (!cache_hit && (stat_misses_q != 32'hFFFF_FFFF)) begin
                stat_misses_d = stat_misses_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_hits_q   <= '0;
            stat_misses_q <= '0;
        end else begin
            stat_hits_q   <= stat_hits_d;
            stat_misses_q <= stat_misses_d;
        end
    end

    assign stat_hits   = stat_hits_q;
    assign stat_misses = stat_misses_q;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a behavioural cache_memory and memory responder.
module tb_cache_controller;

    logic        clk;
    logic        rst;
    logic        cpu_req_valid;
    logic        cpu_req_ready;
    logic [31:0] cpu_addr;
    logic        cpu_resp_valid;
    logic [31:0] cpu_resp_data;
    logic [3:0]  cache_set;
    logic [24:0] cache_tag;
    logic        cache_write_enable;
    logic [1:0]  cache_write_way;
    logic [31:0] cache_write_data;
    logic [31:0] cache_read_data;
    logic        cache_hit;
    logic [1:0]  cache_populate_way;
    logic        cache_populated;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
`ifdef CACHE_STATS_EN
    logic [31:0] stat_hits;
    logic [31:0] stat_misses;
`endif

    cache_controller dut (
        .clk                (clk),
        .rst                (rst),
        .cpu_req_valid      (cpu_req_valid),
        .cpu_req_ready      (cpu_req_ready),
        .cpu_addr           (cpu_addr),
        .cpu_resp_valid     (cpu_resp_valid),
        .cpu_resp_data      (cpu_resp_data),
        .cache_set          (cache_set),
        .cache_tag          (cache_tag),
        .cache_write_enable (cache_write_enable),
        .cache_write_way    (cache_write_way),
        .cache_write_data   (cache_write_data),
        .cache_read_data    (cache_read_data),
        .cache_hit          (cache_hit),
        .cache_populate_way (cache_populate_way),
        .cache_populated    (cache_populated),
        .mem_req_valid      (mem_req_valid),
        .mem_req_ready      (mem_req_ready),
        .mem_addr           (mem_addr),
        .mem_resp_valid     (mem_resp_valid),
        .mem_resp_data      (mem_resp_data)
`ifdef CACHE_STATS_EN
        ,
        .stat_hits          (stat_hits),
        .stat_misses        (stat_misses)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural cache_memory: lowest free way first, synchronous fill
    logic        model_clr;
    logic [24:0] m_tag   [16][4];
    logic        m_valid [16][4];
    logic [31:0] m_data  [16][4];

    always @(posedge clk) begin
        if (model_clr) begin
            for (int s = 0; s < 16; s++)
                for (int w = 0; w < 4; w++) m_valid[s][w] <= 1'b0;
        end else if (cache_write_enable) begin
            m_valid[cache_set][cache_write_way] <= 1'b1;
            m_tag[cache_set][cache_write_way]   <= cache_tag;
            m_data[cache_set][cache_write_way]  <= cache_write_data;
        end
    end

    always_comb begin
        logic found;
        cache_hit          = 1'b0;
        cache_read_data    = '0;
        cache_populated    = 1'b1;
        cache_populate_way = '0;
        found              = 1'b0;
        for (int w = 0; w < 4; w++) begin
            if (m_valid[cache_set][w] && m_tag[cache_set][w] == cache_tag) begin
                cache_hit       = 1'b1;
                cache_read_data = m_data[cache_set][w];
            end
            if (!m_valid[cache_set][w] && !found) begin
                found              = 1'b1;
                cache_populated    = 1'b0;
                cache_populate_way = 2'(w);
            end
        end
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] mdata;
        int          stall;
        logic        exp_hit;
        logic [1:0]  exp_way;
        logic [31:0] exp_maddr;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    int n_cmp;
    int n_err;
    int exp_hits;
    int exp_misses;

    task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0h want %0h", name, idx, act, exp);
        end
    endtask

    // Issue one request, play memory, and observe the whole transaction
    task automatic apply_vec(input vec_t v, input int idx);
        logic        got_resp, used_mem, wr_seen, ready_bad, stable_bad;
        logic [31:0] rdata, maddr;
        logic [1:0]  wway;
        int          cyc, lat, phase, wait_cnt, guard;
        got_resp = 0; used_mem = 0; wr_seen = 0; ready_bad = 0; stable_bad = 0;
        rdata = '0; maddr = '0; wway = '0; lat = -1; phase = 0; wait_cnt = 0;

        @(negedge clk);
        guard = 0;
        while (!cpu_req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("req_ready", idx, 64'(cpu_req_ready), 64'd1);
        cpu_req_valid = 1'b1;
        cpu_addr      = v.addr;
        @(posedge clk);
        @(negedge clk);
        cpu_req_valid = 1'b0;
        cyc = 1;
        while (!got_resp && cyc < 60) begin
            if (cpu_req_ready) ready_bad = 1;
            if (cache_write_enable) begin
                wr_seen = 1;
                wway    = cache_write_way;
            end
            if (cpu_resp_valid) begin
                got_resp = 1;
                rdata    = cpu_resp_data;
                lat      = cyc;
            end
            case (phase)
                0: begin
                    if (used_mem && (!mem_req_valid || mem_addr != maddr)) stable_bad = 1;
                    if (mem_req_valid) begin
                        if (!used_mem) begin
                            used_mem = 1;
                            maddr    = mem_addr;
                        end
                        if (wait_cnt >= v.stall) begin
                            mem_req_ready = 1'b1;
                            phase = 1;
                        end else begin
                            wait_cnt++;
                        end
                    end
                end
                1: begin
                    if (mem_req_valid) stable_bad = 1;
                    mem_req_ready  = 1'b0;
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = v.mdata;
                    phase = 2;
                end
                2: begin
                    mem_resp_valid = 1'b0;
                    phase = 3;
                end
                default: ;
            endcase
            if (!got_resp) begin
                @(negedge clk);
                cyc++;
            end
        end
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;

        chk("resp_seen", idx, 64'(got_resp), 64'd1);
        chk("resp_data", idx, 64'(rdata), 64'(v.exp_data));
        chk("latency", idx, 64'(lat), 64'(v.exp_lat));
        chk("mem_used", idx, 64'(used_mem), 64'(!v.exp_hit));
        chk("ready_low", idx, 64'(ready_bad), 64'd0);
        if (!v.exp_hit) begin
            chk("mem_addr", idx, 64'(maddr), 64'(v.exp_maddr));
            chk("fill_seen", idx, 64'(wr_seen), 64'd1);
            chk("fill_way", idx, 64'(wway), 64'(v.exp_way));
            chk("req_stable", idx, 64'(stable_bad), 64'd0);
        end
        if (v.exp_hit) exp_hits++;
        else exp_misses++;
    endtask

    vec_t vecs[$];

    initial begin
        vec_t v;
        logic bad;
        n_cmp = 0; n_err = 0; exp_hits = 0; exp_misses = 0;
        rst = 1'b0; model_clr = 1'b1;
        cpu_req_valid = 1'b0; cpu_addr = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;

        // addr, mdata, stall, hit, way, mem_addr, resp_data, latency
        vecs.push_back('{32'h0000_1040, 32'hDEAD_BEEF, 0, 1'b0, 2'd0, 32'h0000_1040, 32'hDEAD_BEEF, 5});
        vecs.push_back('{32'h0000_1040, 32'h0,         0, 1'b1, 2'd0, 32'h0,         32'hDEAD_BEEF, 2});
        vecs.push_back('{32'h0000_0090, 32'hA000_0000, 0, 1'b0, 2'd0, 32'h0000_0090, 32'hA000_0000, 5});
        vecs.push_back('{32'h0000_0110, 32'hA000_0001, 0, 1'b0, 2'd1, 32'h0000_0110, 32'hA000_0001, 5});
        vecs.push_back('{32'h0000_0190, 32'hA000_0002, 0, 1'b0, 2'd2, 32'h0000_0190, 32'hA000_0002, 5});
        vecs.push_back('{32'h0000_0210, 32'hA000_0003, 0, 1'b0, 2'd3, 32'h0000_0210, 32'hA000_0003, 5});
        vecs.push_back('{32'h0000_0290, 32'hA000_0004, 0, 1'b0, 2'd0, 32'h0000_0290, 32'hA000_0004, 5});
        vecs.push_back('{32'h0000_0310, 32'hA000_0005, 0, 1'b0, 2'd1, 32'h0000_0310, 32'hA000_0005, 5});
        vecs.push_back('{32'h0000_0090, 32'hB000_0000, 0, 1'b0, 2'd2, 32'h0000_0090, 32'hB000_0000, 5});
        vecs.push_back('{32'h0000_0210, 32'h0,         0, 1'b1, 2'd0, 32'h0,         32'hA000_0003, 2});
        vecs.push_back('{32'h0000_2035, 32'hC000_0000, 7, 1'b0, 2'd0, 32'h0000_2030, 32'hC000_0000, 12});
        vecs.push_back('{32'h0000_00B0, 32'hC000_0001, 0, 1'b0, 2'd1, 32'h0000_00B0, 32'hC000_0001, 5});
        vecs.push_back('{32'h0000_0130, 32'hC000_0002, 0, 1'b0, 2'd2, 32'h0000_0130, 32'hC000_0002, 5});
        vecs.push_back('{32'h0000_01B0, 32'hC000_0003, 0, 1'b0, 2'd3, 32'h0000_01B0, 32'hC000_0003, 5});
        vecs.push_back('{32'h0000_0230, 32'hC000_0004, 0, 1'b0, 2'd0, 32'h0000_0230, 32'hC000_0004, 5});
        vecs.push_back('{32'h0000_00B0, 32'h0,         0, 1'b1, 2'd0, 32'h0,         32'hC000_0001, 2});
        vecs.push_back('{32'h0000_2035, 32'hC000_0005, 0, 1'b0, 2'd1, 32'h0000_2030, 32'hC000_0005, 5});

        // Reset values while reset is held
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 0, 64'(cpu_req_ready), 64'd0);
        chk("rst_resp_valid", 0, 64'(cpu_resp_valid), 64'd0);
        chk("rst_mem_valid", 0, 64'(mem_req_valid), 64'd0);
        chk("rst_wr_en", 0, 64'(cache_write_enable), 64'd0);
        chk("rst_set_tag", 0, 64'({cache_set, cache_tag}), 64'd0);
        model_clr = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("idle_ready", 0, 64'(cpu_req_ready), 64'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            apply_vec(vecs[i], i);
        end

`ifdef CACHE_STATS_EN
        @(negedge clk);
        chk("stat_hits", 0, 64'(stat_hits), 64'(exp_hits));
        chk("stat_misses", 0, 64'(stat_misses), 64'(exp_misses));
`endif

        // Reset in MEM_WAIT, then a stray memory response
        @(negedge clk);
        cpu_req_valid = 1'b1;
        cpu_addr      = 32'h0000_3000;
        @(negedge clk);
        cpu_req_valid = 1'b0;
        @(negedge clk);
        chk("mr_mem_valid", 0, 64'(mem_req_valid), 64'd1);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        rst = 1'b0;
        #1;
        chk("mr_req_valid", 1, 64'(mem_req_valid), 64'd0);
        chk("mr_mem_addr", 1, 64'(mem_addr), 64'd0);
        chk("mr_req_ready", 1, 64'(cpu_req_ready), 64'd0);
        chk("mr_resp", 1, 64'({cpu_resp_valid, cpu_resp_data}), 64'd0);
        chk("mr_wr", 1, 64'({cache_write_enable, cache_write_way, cache_write_data}), 64'd0);
        chk("mr_set_tag", 1, 64'({cache_set, cache_tag}), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hBAD0_BAD0;
        bad = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 1) mem_resp_valid = 1'b0;
            if (cache_write_enable || cpu_resp_valid) bad = 1'b1;
        end
        chk("stray_resp", 0, 64'(bad), 64'd0);
        chk("post_rst_ready", 0, 64'(cpu_req_ready), 64'd1);

        // Set 2 is still full in cache_memory; pointer restarts at way 0
        v = '{32'h0000_0390, 32'hD000_0000, 0, 1'b0, 2'd0, 32'h0000_0390, 32'hD000_0000, 5};
        exp_hits = 0; exp_misses = 0;
        apply_vec(v, 100);
`ifdef CACHE_STATS_EN
        @(negedge clk);
        chk("stat_hits_rst", 0, 64'(stat_hits), 64'(exp_hits));
        chk("stat_misses_rst", 0, 64'(stat_misses), 64'(exp_misses));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
